interrupt_arbiter: RTL and testbench

- Multi-source interrupt controller in front of the MCU's single interrupt input.
- Edge-detects several request lines (buttons, timers, peripherals) into pending latches and applies a per-source enable mask.
- Picks one source by fixed priority, drives a fixed-length interrupt pulse and exposes the winner's ID on an input port for the ISR.
- Holds off further interrupts until the ISR acknowledges, then frees the slot.

---
 rtl/interrupt_arbiter.sv | 152 +++++++++++++++
 tb/tb_interrupt_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter
// Multi-source interrupt controller feeding a single MCU interrupt line.
// Rising edges on req[] latch into pending[]. The enable mask selects which
// pending sources may be dispatched, with index 0 having the highest priority.
// A dispatch drives int_out for PULSE_CYCLES cycles and shows the winner on
// src_id. No new dispatch starts until the ISR acknowledges the current one.
//
// Handshake: ack is a single-cycle strobe. It is accepted while a dispatch
// is in flight: in ASSERT before any earlier ack, or in WAIT_ACK. An accepted
// ack clears pending[src_id] at that edge. A rise on the same bit at that edge
// wins, so the bit stays pending. Ack while idle has no effect.
module interrupt_arbiter #(
    parameter int                   NUM_SRC      = 4,
    parameter int                   PULSE_CYCLES = 7,
    parameter logic [NUM_SRC-1:0]   MASK_RST     = '1,
    localparam int                  SRC_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               ack,
    output logic               int_out,
    output logic [SRC_W-1:0]   src_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSERT   = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_SRC-1:0] r_req_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [SRC_W-1:0]   r_src_id;
    logic [7:0]         r_cnt;
    logic               r_ack_seen;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_clr;
    logic [SRC_W-1:0]   w_winner;
    logic               w_ack_acc;
    logic               w_dispatch;
    logic               w_pulse_end;

    assign w_rise      = req & ~r_req_d;
    assign w_elig      = r_pending & r_mask;
    assign w_dispatch  = (r_state == S_IDLE) && (|w_elig);
    assign w_pulse_end = (r_cnt == 8'(PULSE_CYCLES));
    // Only the first ack of a dispatch counts. A later ack in the same pulse
    // must not clear a fresh rise on the serviced source.
    assign w_ack_acc   = ack && (((r_state == S_ASSERT) && !r_ack_seen) ||
                                 (r_state == S_WAIT_ACK));
    assign w_clr       = w_ack_acc ? (NUM_SRC'(1) << r_src_id) : '0;

    // Fixed-priority pick: the lowest set index in elig wins.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = SRC_W'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (w_pulse_end) begin
                    w_state_nxt = (r_ack_seen || w_ack_acc) ? S_IDLE : S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs. These are Moore decodes of the state register: the pulse
    // is high exactly while in ASSERT, and busy is high until the return to IDLE.
    always_comb begin
        int_out   = (r_state == S_ASSERT);
        busy      = (r_state != S_IDLE);
        dbg_state = r_state;
    end

    // Per-dispatch context: pulse counter, winner ID, early-ack flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 8'd0;
            r_src_id   <= '0;
            r_ack_seen <= 1'b0;
        end else if (w_dispatch) begin
            r_cnt      <= 8'd1;
            r_src_id   <= w_winner;
            r_ack_seen <= 1'b0;
        end else if (r_state == S_ASSERT) begin
            r_cnt <= w_pulse_end ? 8'd0 : r_cnt + 8'd1;
            if (w_ack_acc) begin
                r_ack_seen <= 1'b1;
            end
        end
    end

    // Edge history, pending latches (set beats clear) and mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d   <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RST;
        end else begin
            r_req_d   <= req;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_din;
            end
        end
    end

    assign src_id  = r_src_id;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Testbench for interrupt_arbiter. It uses table vectors for the basic
// dispatch/ack flow, hand-written corner sequences, and a randomized run
// checked against a behavioural model.
module tb_interrupt_arbiter;

    localparam int NS = 4;
    localparam int PC = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] req;
    logic          mask_we;
    logic [NS-1:0] mask_din;
    logic          ack;
    logic          int_out;
    logic [1:0]    src_id;
    logic [NS-1:0] pending;
    logic [NS-1:0] mask;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    interrupt_arbiter #(.NUM_SRC(NS), .PULSE_CYCLES(PC), .MASK_RST(4'hF)) dut (
        .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_din(mask_din),
        .ack(ack), .int_out(int_out), .src_id(src_id), .pending(pending),
        .mask(mask), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [NS-1:0] m_pend, m_prev, m_mask;
    bit            m_serving, m_acked;
    int            m_left;   // remaining high cycles of the current pulse
    int            m_id;

    function automatic void model_reset();
        m_pend = '0; m_prev = '0; m_mask = 4'hF;
        m_serving = 0; m_acked = 0; m_left = 0; m_id = 0;
    endfunction

    function automatic void model_edge();
        logic [NS-1:0] rise, clr;
        bit accept;
        if (rst) begin
            model_reset();
            return;
        end
        rise   = req & ~m_prev;
        accept = m_serving && !m_acked && ack;
        clr    = accept ? NS'(1 << m_id) : '0;
        if (m_serving) begin
            if (m_left > 0) begin
                if (m_left == 1) begin
                    m_left = 0;
                    if (m_acked || accept) m_serving = 0;
                end else begin
                    m_left = m_left - 1;
                end
                if (accept) m_acked = 1;
            end else if (accept) begin
                m_serving = 0;
            end
        end else if ((m_pend & m_mask) != '0) begin
            for (int i = NS - 1; i >= 0; i--)
                if (m_pend[i] && m_mask[i]) m_id = i;
            m_serving = 1;
            m_left    = PC;
            m_acked   = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (mask_we) m_mask = mask_din;
        m_prev = req;
    endfunction

    // ---------------- scoreboard helpers ----------------
    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic check_model();
        chk("int_out", int'(int_out), int'(m_left > 0));
        chk("busy",    int'(busy),    int'(m_serving));
        chk("src_id",  int'(src_id),  m_id);
        chk("pending", int'(pending), int'(m_pend));
        chk("mask",    int'(mask),    int'(m_mask));
    endtask

    // Drive inputs, take one edge, update the model, sample 1 time unit later.
    task automatic run(input logic r, input logic [NS-1:0] rq, input logic mwe,
                       input logic [NS-1:0] md, input logic a);
        rst = r; req = rq; mask_we = mwe; mask_din = md; ack = a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc(input logic r, input logic [NS-1:0] rq, input logic mwe,
                       input logic [NS-1:0] md, input logic a);
        run(r, rq, mwe, md, a);
        check_model();
    endtask

    // Hold the current req until the block sits waiting for ack.
    task automatic wait_ack_state(input string name);
        int k = 0;
        while (!(busy && !int_out) && k < 20) begin
            cyc(0, req, 0, 4'h0, 0);
            k++;
        end
        chk(name, int'(busy && !int_out), 1);
    endtask

    // Drop all requests and acknowledge until idle.
    task automatic drain(input string name);
        int k = 0;
        while (busy && k < 30) begin
            cyc(0, 4'h0, 0, 4'h0, !int_out);
            k++;
        end
        cyc(0, 4'h0, 0, 4'h0, 0);
        chk(name, int'(busy), 0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic          rst;
        logic [NS-1:0] req;
        logic          ack;
        logic          exp_int;
        logic          exp_busy;
        logic [1:0]    exp_src;
        logic [NS-1:0] exp_pend;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic r, logic [NS-1:0] rq, logic a, logic ei,
                                logic eb, logic [1:0] es, logic [NS-1:0] ep);
        vec_t v;
        v.rst = r; v.req = rq; v.ack = a; v.exp_int = ei;
        v.exp_busy = eb; v.exp_src = es; v.exp_pend = ep;
        return v;
    endfunction

    initial begin
        int hi;
        logic [NS-1:0] flip;

        rst = 1'b1; req = '0; mask_we = 1'b0; mask_din = '0; ack = 1'b0;
        model_reset();

        // Single event on req[2], 7-cycle pulse, ack, no re-trigger while held.
        tbl[0] = mk(1, 4'h0, 0, 0, 0, 2'd0, 4'h0);
        tbl[1] = mk(0, 4'h4, 0, 0, 0, 2'd0, 4'h4);
        for (int i = 2; i <= 8; i++) tbl[i] = mk(0, 4'h4, 0, 1, 1, 2'd2, 4'h4);
        tbl[9]  = mk(0, 4'h4, 0, 0, 1, 2'd2, 4'h4);
        tbl[10] = mk(0, 4'h4, 0, 0, 1, 2'd2, 4'h4);
        tbl[11] = mk(0, 4'h4, 1, 0, 0, 2'd2, 4'h0);
        tbl[12] = mk(0, 4'h4, 0, 0, 0, 2'd2, 4'h0);
        tbl[13] = mk(0, 4'h4, 0, 0, 0, 2'd2, 4'h0);

        for (int i = 0; i < 14; i++) begin
            run(tbl[i].rst, tbl[i].req, 0, 4'h0, tbl[i].ack);
            chk($sformatf("tbl%0d_int", i),  int'(int_out), int'(tbl[i].exp_int));
            chk($sformatf("tbl%0d_busy", i), int'(busy),    int'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_src", i),  int'(src_id),  int'(tbl[i].exp_src));
            chk($sformatf("tbl%0d_pend", i), int'(pending), int'(tbl[i].exp_pend));
            chk($sformatf("tbl%0d_mask", i), int'(mask),    15);
        end

        // Priority: req[3] and req[1] rise together.
        cyc(0, 4'h0, 0, 4'h0, 0);
        cyc(0, 4'hA, 0, 4'h0, 0);
        chk("prio_pend", int'(pending), 10);
        cyc(0, 4'hA, 0, 4'h0, 0);
        chk("prio_first_int", int'(int_out), 1);
        chk("prio_first_src", int'(src_id), 1);
        wait_ack_state("prio_wait1");
        cyc(0, 4'hA, 0, 4'h0, 1);
        chk("prio_gap_int", int'(int_out), 0);
        cyc(0, 4'hA, 0, 4'h0, 0);
        chk("prio_second_int", int'(int_out), 1);
        chk("prio_second_src", int'(src_id), 3);
        wait_ack_state("prio_wait2");
        drain("prio_drain");

        // Masking: masked rise latches but does not dispatch.
        cyc(0, 4'h0, 1, 4'hE, 0);
        chk("mask_write", int'(mask), 14);
        cyc(0, 4'h1, 0, 4'h0, 0);
        chk("mask_pend0", int'(pending[0]), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 4'h1, 0, 4'h0, 0);
            chk("mask_hold_int", int'(int_out), 0);
        end
        cyc(0, 4'h1, 1, 4'hF, 0);
        chk("mask_unmask_int", int'(int_out), 0);
        cyc(0, 4'h1, 0, 4'h0, 0);
        chk("mask_dispatch_int", int'(int_out), 1);
        chk("mask_dispatch_src", int'(src_id), 0);

        // Early ack during the pulse: full length, no wait-for-ack phase.
        hi = 1;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 4'h1, 0, 4'h0, k == 1);
            if (!int_out) break;
            hi++;
        end
        chk("early_pulse_len", hi, PC);
        chk("early_busy_fall", int'(busy), 0);
        chk("early_pend_clr", int'(pending[0]), 0);
        drain("early_drain");

        // Reset mid-pulse with two pending sources.
        cyc(0, 4'h0, 1, 4'h7, 0);
        cyc(0, 4'hA, 0, 4'h0, 0);
        cyc(0, 4'hA, 0, 4'h0, 0);
        chk("rst_pre_int", int'(int_out), 1);
        cyc(0, 4'hA, 0, 4'h0, 0);
        cyc(0, 4'hA, 0, 4'h0, 0);
        chk("rst_pre_pend", int'(pending), 10);
        cyc(1, 4'h0, 0, 4'h0, 0);
        chk("rst_int", int'(int_out), 0);
        chk("rst_pend", int'(pending), 0);
        chk("rst_mask", int'(mask), 15);
        chk("rst_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 4'h0, 0, 4'h0, 0);
            chk("rst_no_dispatch", int'(busy), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            flip = '0;
            for (int b = 0; b < NS; b++) flip[b] = ($urandom_range(0, 5) == 0);
            cyc(($urandom_range(0, 299) == 0), req ^ flip,
                ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
